// File: rtl/uart_sram_burst_bridge_pkg.sv
// Shared types for the UART<->SRAM burst bridge.
// State codes double as the debug nibble on dpy0.
package uart_sram_burst_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RX_WAIT = 4'd1,
    ST_RX_RD   = 4'd2,
    ST_RAM_WR  = 4'd3,
    ST_RAM_RD  = 4'd4,
    ST_TX_WR   = 4'd5,
    ST_TX_TBRE = 4'd6,
    ST_TX_TSRE = 4'd7,
    ST_FIN     = 4'd8
  } state_t;

  localparam logic [1:0] MODE_LOOP  = 2'b00;
  localparam logic [1:0] MODE_CAP   = 2'b01;
  localparam logic [1:0] MODE_DUMP  = 2'b10;
  localparam logic [1:0] MODE_LOOP2 = 2'b11;

  function automatic logic [3:0] lane_be_n(
    input logic [1:0] lane
  );
    lane_be_n = ~(4'b0001 << lane);
  endfunction

  function automatic logic [7:0] lane_sel(
    input logic [31:0] w,
    input logic [1:0]  lane
  );
    lane_sel = w[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_sram_burst_bridge_uart_cpld_if.sv
// Strobe timing and TX handshake gating for the CPLD UART / SRAM bus.
// One counter paces every strobe state; write states add a data hold tail.
module uart_sram_burst_bridge_uart_cpld_if #(
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_req,
  input  logic wr_req,
  input  logic mem_rd_req,
  input  logic mem_wr_req,
  input  logic tbre_wait,
  input  logic tsre_wait,
  input  logic uart_tbre,
  input  logic uart_tsre,
  output logic strobe,
  output logic last_low,
  output logic step_done,
  output logic tbre_ok,
  output logic tsre_ok,
  output logic uart_rdn,
  output logic uart_wrn
);

  localparam int SPAN = PULSE_CYC + HOLD_CYC;
  localparam int CW   = $clog2(SPAN + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] end_cnt;
  logic          active;
  logic          write_side;

  assign active     = rd_req | wr_req
                    | mem_rd_req | mem_wr_req;
  assign write_side = wr_req | mem_wr_req;

  assign end_cnt = write_side ? CW'(SPAN - 1)
                              : CW'(PULSE_CYC - 1);

  assign strobe    = active && (cnt < CW'(PULSE_CYC));
  assign last_low  = active && (cnt == CW'(PULSE_CYC - 1));
  assign step_done = active && (cnt == end_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || step_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tbre_ok  = tbre_wait & uart_tbre;
  assign tsre_ok  = tsre_wait & uart_tsre;
  assign uart_rdn = ~(rd_req & strobe);
  assign uart_wrn = ~(wr_req & strobe);

endmodule

// File: rtl/uart_sram_burst_bridge.sv
// Burst mover between the CPLD UART and BaseRAM on the shared bus.
// Bytes pack four per word; loopback, capture and dump modes.
module uart_sram_burst_bridge
  import uart_sram_burst_bridge_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int LEN_W     = 8,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [7:0]        tx_delta,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byte_cnt,
  output logic [3:0]        state_o,
  inout  wire  [31:0]       ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              uart_dataready,
  input  logic              uart_tbre,
  input  logic              uart_tsre
);

  state_t state;
  state_t state_nx;

  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [7:0]        delta_q;
  logic [7:0]        byte_q;
  logic              busy_q;
  logic              done_q;

  logic strobe;
  logic last_low;
  logic step_done;
  logic tbre_ok;
  logic tsre_ok;

  logic [1:0]  lane;
  logic        last_byte;
  logic [7:0]  tx_byte;
  logic        drv_lo;
  logic        drv_hi;
  logic [31:0] wdata;

  assign lane      = cnt_q[1:0];
  assign last_byte = (cnt_q + LEN_W'(1)) == len_q;
  assign tx_byte   = byte_q + delta_q;
  assign ram_addr  = addr_q + ADDR_W'(cnt_q >> 2);

  uart_sram_burst_bridge_uart_cpld_if #(
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_cpld_if (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (state == ST_RX_RD),
    .wr_req     (state == ST_TX_WR),
    .mem_rd_req (state == ST_RAM_RD),
    .mem_wr_req (state == ST_RAM_WR),
    .tbre_wait  (state == ST_TX_TBRE),
    .tsre_wait  (state == ST_TX_TSRE),
    .uart_tbre  (uart_tbre),
    .uart_tsre  (uart_tsre),
    .strobe     (strobe),
    .last_low   (last_low),
    .step_done  (step_done),
    .tbre_ok    (tbre_ok),
    .tsre_ok    (tsre_ok),
    .uart_rdn   (uart_rdn),
    .uart_wrn   (uart_wrn)
  );

  always_comb begin
    state_nx = state;
    ram_ce_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    ram_be_n = 4'hF;
    drv_lo   = 1'b0;
    drv_hi   = 1'b0;
    wdata    = '0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (burst_len == '0) begin
            state_nx = ST_FIN;
          end else if (mode == MODE_DUMP) begin
            state_nx = ST_RAM_RD;
          end else begin
            state_nx = ST_RX_WAIT;
          end
        end
      end
      ST_RX_WAIT: begin
        if (uart_dataready) state_nx = ST_RX_RD;
      end
      ST_RX_RD: begin
        if (step_done) state_nx = ST_RAM_WR;
      end
      ST_RAM_WR: begin
        ram_ce_n = ~strobe;
        ram_we_n = ~strobe;
        ram_be_n = lane_be_n(lane);
        drv_lo   = 1'b1;
        drv_hi   = 1'b1;
        wdata    = {4{byte_q}};
        if (step_done) begin
          if (!last_byte) begin
            state_nx = ST_RX_WAIT;
          end else if (mode_q == MODE_CAP) begin
            state_nx = ST_FIN;
          end else begin
            state_nx = ST_RAM_RD;
          end
        end
      end
      ST_RAM_RD: begin
        ram_ce_n = ~strobe;
        ram_oe_n = ~strobe;
        ram_be_n = 4'h0;
        if (step_done) state_nx = ST_TX_WR;
      end
      ST_TX_WR: begin
        drv_lo = 1'b1;
        wdata  = {24'h0, tx_byte};
        if (step_done) state_nx = ST_TX_TBRE;
      end
      ST_TX_TBRE: begin
        if (tbre_ok) state_nx = ST_TX_TSRE;
      end
      ST_TX_TSRE: begin
        if (tsre_ok) begin
          state_nx = last_byte ? ST_FIN : ST_RAM_RD;
        end
      end
      ST_FIN: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      delta_q <= '0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == ST_FIN);
      if (state == ST_IDLE && start) begin
        mode_q  <= mode;
        addr_q  <= start_addr;
        len_q   <= burst_len;
        delta_q <= tx_delta;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
      if (state == ST_FIN) busy_q <= 1'b0;
      if (state == ST_RX_RD && last_low) begin
        byte_q <= ram_data[7:0];
      end
      if (state == ST_RAM_RD && last_low) begin
        byte_q <= lane_sel(ram_data, lane);
      end
      // loopback restarts the count for the readback phase
      if (state == ST_RAM_WR && step_done) begin
        cnt_q <= (last_byte && mode_q != MODE_CAP)
               ? '0 : cnt_q + LEN_W'(1);
      end
      if (state == ST_TX_TSRE && tsre_ok) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  assign ram_data[7:0]  = drv_lo ? wdata[7:0]  : 8'hzz;
  assign ram_data[31:8] = drv_hi ? wdata[31:8] : 24'hzz_zzzz;

  assign busy     = busy_q;
  assign done     = done_q;
  assign byte_cnt = cnt_q;
  assign state_o  = state;

endmodule

// File: tb/tb_uart_sram_burst_bridge.sv
// Bench for uart_sram_burst_bridge: SRAM and CPLD UART models,
// TX scoreboard queue and one task per scenario.
`timescale 1ns/1ps
module tb_uart_sram_burst_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [19:0] start_addr = '0;
  logic [7:0]  burst_len = '0;
  logic [7:0]  tx_delta = '0;
  logic        busy;
  logic        done;
  logic [7:0]  byte_cnt;
  logic [3:0]  state_o;
  wire  [31:0] ram_data;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        uart_rdn;
  logic        uart_wrn;
  logic        uart_dataready = 1'b0;
  logic        uart_tbre = 1'b1;
  logic        uart_tsre = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [19:0]];
  logic [7:0]  rx_q [$];
  logic [7:0]  tx_exp [$];
  logic [7:0]  rx_head = 8'h00;

  int rx_delay = 0;
  int rx_timer = 0;
  int tbre_delay = 3;
  int tsre_delay = 2;
  int tx_timer = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  int rdn_early = 0;
  int wr_early = 0;
  int strobe_act = 0;

  logic        prev_rdn = 1'b1;
  logic        prev_wrn = 1'b1;
  logic [31:0] wtmp;
  logic [7:0]  txe;

  logic        tb_en;
  logic [31:0] tb_val;

  assign ram_data = tb_en ? tb_val : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  uart_sram_burst_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .start_addr     (start_addr),
    .burst_len      (burst_len),
    .tx_delta       (tx_delta),
    .busy           (busy),
    .done           (done),
    .byte_cnt       (byte_cnt),
    .state_o        (state_o),
    .ram_data       (ram_data),
    .ram_addr       (ram_addr),
    .ram_be_n       (ram_be_n),
    .ram_ce_n       (ram_ce_n),
    .ram_oe_n       (ram_oe_n),
    .ram_we_n       (ram_we_n),
    .uart_rdn       (uart_rdn),
    .uart_wrn       (uart_wrn),
    .uart_dataready (uart_dataready),
    .uart_tbre      (uart_tbre),
    .uart_tsre      (uart_tsre)
  );

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always_comb begin
    tb_en  = 1'b0;
    tb_val = '0;
    if (!uart_rdn) begin
      tb_en  = 1'b1;
      tb_val = {24'h0, rx_head};
    end else if (!ram_ce_n && !ram_oe_n) begin
      tb_en  = 1'b1;
      tb_val = mem_word(ram_addr);
    end
  end

  // bus models and TX scoreboard, evaluated mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!ram_ce_n && (!uart_rdn || !uart_wrn)) viol++;
      if (!ram_oe_n && state_o != 4'd4) viol++;
      if (!ram_ce_n || !uart_rdn || !uart_wrn) strobe_act++;
      if (done) done_cnt++;
      if (!uart_rdn && !uart_dataready) rdn_early++;
      if (!ram_ce_n && !ram_we_n) begin
        wtmp = mem_word(ram_addr);
        for (int l = 0; l < 4; l++) begin
          if (!ram_be_n[l]) wtmp[8*l +: 8] = ram_data[8*l +: 8];
        end
        mem[ram_addr] = wtmp;
      end
      if (!prev_rdn && uart_rdn) begin
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        rx_head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        uart_dataready = 1'b0;
        rx_timer = 0;
      end else if (!uart_dataready && rx_q.size() > 0) begin
        if (rx_timer >= rx_delay) uart_dataready = 1'b1;
        else rx_timer++;
      end
      if (prev_wrn && !uart_wrn) begin
        tx_cnt++;
        if (!uart_tsre) wr_early++;
        checks++;
        if (tx_exp.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected got %h want none", ram_data[7:0]);
        end else begin
          txe = tx_exp.pop_front();
          if (ram_data[7:0] !== txe) begin
            errors++;
            $display("FAIL tx_byte got %h want %h", ram_data[7:0], txe);
          end
        end
        uart_tbre = 1'b0;
        uart_tsre = 1'b0;
        tx_timer = 0;
      end else if (!uart_tsre) begin
        tx_timer++;
        if (tx_timer >= tbre_delay) uart_tbre = 1'b1;
        if (tx_timer >= tbre_delay + tsre_delay) uart_tsre = 1'b1;
      end
      prev_rdn = uart_rdn;
      prev_wrn = uart_wrn;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
    rx_head = rx_q[0];
  endtask

  task automatic do_start(input logic [1:0] m, input logic [19:0] a,
                          input logic [7:0] l, input logic [7:0] d);
    mode = m;
    start_addr = a;
    burst_len = l;
    tx_delta = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn} !== 5'b11111) begin
      errors++;
      $display("FAIL rst_strobes got %b want 11111",
               {ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn});
    end
    checks++;
    if (ram_be_n !== 4'hF) begin
      errors++;
      $display("FAIL rst_be_n got %h want f", ram_be_n);
    end
    checks++;
    if (ram_addr !== 20'h0) begin
      errors++;
      $display("FAIL rst_addr got %h want 0", ram_addr);
    end
    checks++;
    if ({busy, done} !== 2'b00 || byte_cnt !== 8'h0) begin
      errors++;
      $display("FAIL rst_status got %b/%h want 00/00", {busy, done}, byte_cnt);
    end
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL rst_state got %0d want 0", state_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_loopback();
    bit ok;
    int d0 = done_cnt;
    rx_delay = 0;
    for (int i = 0; i < 5; i++) begin
      push_rx(8'(8'h41 + i));
      tx_exp.push_back(8'(8'h42 + i));
    end
    do_start(2'b00, 20'h100, 8'd5, 8'd1);
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loop_done got timeout want done");
    end
    tick();
    tick();
    checks++;
    if (mem_word(20'h100) !== 32'h4443_4241) begin
      errors++;
      $display("FAIL loop_w0 got %h want 44434241", mem_word(20'h100));
    end
    checks++;
    if (mem_word(20'h101) !== 32'h0000_0045) begin
      errors++;
      $display("FAIL loop_w1 got %h want 00000045", mem_word(20'h101));
    end
    checks++;
    if (tx_exp.size() != 0) begin
      errors++;
      $display("FAIL loop_tx_left got %0d want 0", tx_exp.size());
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL loop_done_cnt got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (byte_cnt !== 8'd5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_end got %0d/%b want 5/0", byte_cnt, busy);
    end
  endtask

  task automatic test_capture();
    bit ok;
    int t0 = tx_cnt;
    int r0 = rdn_early;
    rx_delay = 37;
    rx_timer = 0;
    push_rx(8'h11);
    push_rx(8'h22);
    push_rx(8'h33);
    push_rx(8'h44);
    do_start(2'b01, 20'h300, 8'd4, 8'd9);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cap_done got timeout want done");
    end
    checks++;
    if (mem_word(20'h300) !== 32'h4433_2211) begin
      errors++;
      $display("FAIL cap_word got %h want 44332211", mem_word(20'h300));
    end
    checks++;
    if (tx_cnt != t0) begin
      errors++;
      $display("FAIL cap_no_tx got %0d want 0", tx_cnt - t0);
    end
    checks++;
    if (rdn_early != r0) begin
      errors++;
      $display("FAIL cap_rdn_early got %0d want 0", rdn_early - r0);
    end
    checks++;
    if (byte_cnt !== 8'd4) begin
      errors++;
      $display("FAIL cap_cnt got %0d want 4", byte_cnt);
    end
    rx_delay = 0;
  endtask

  task automatic test_dump();
    bit ok;
    int t0 = tx_cnt;
    int w0 = wr_early;
    mem[20'h200] = 32'hAABB_CCDD;
    tsre_delay = 20;
    tx_exp.push_back(8'hDD);
    tx_exp.push_back(8'hCC);
    tx_exp.push_back(8'hBB);
    do_start(2'b10, 20'h200, 8'd3, 8'd0);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dump_done got timeout want done");
    end
    checks++;
    if (tx_cnt - t0 != 3 || tx_exp.size() != 0) begin
      errors++;
      $display("FAIL dump_tx_cnt got %0d want 3", tx_cnt - t0);
    end
    checks++;
    if (wr_early != w0) begin
      errors++;
      $display("FAIL dump_wr_early got %0d want 0", wr_early - w0);
    end
    tsre_delay = 2;
  endtask

  task automatic test_zero_len();
    int s0 = strobe_act;
    do_start(2'b00, 20'h10, 8'd0, 8'd5);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zl_fin got %b/%b want 0/1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL zl_done got %b want 1", done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL zl_busy got %b want 0", busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL zl_after got %b/%0d want 0/0", done, state_o);
    end
    checks++;
    if (strobe_act != s0) begin
      errors++;
      $display("FAIL zl_strobes got %0d want 0", strobe_act - s0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 1'b0;
    push_rx(8'h77);
    push_rx(8'h88);
    push_rx(8'h99);
    do_start(2'b01, 20'h500, 8'd3, 8'd0);
    for (int i = 0; i < 200; i++) begin
      if (state_o === 4'd3) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rm_reach got %0d want 3", state_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ram_we_n, ram_ce_n, ram_oe_n} !== 3'b111) begin
      errors++;
      $display("FAIL rm_strobes got %b want 111",
               {ram_we_n, ram_ce_n, ram_oe_n});
    end
    checks++;
    if (busy !== 1'b0 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL rm_state got %b/%0d want 0/0", busy, state_o);
    end
    checks++;
    if (ram_be_n !== 4'hF || byte_cnt !== 8'h0) begin
      errors++;
      $display("FAIL rm_be_cnt got %h/%0d want f/0", ram_be_n, byte_cnt);
    end
    rst = 1'b0;
    rx_q.delete();
    rx_head = 8'h00;
    uart_dataready = 1'b0;
    rx_timer = 0;
    tick();
    push_rx(8'h5A);
    push_rx(8'hA5);
    do_start(2'b01, 20'h400, 8'd2, 8'd0);
    wait_done(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rm_fresh_done got timeout want done");
    end
    checks++;
    if (mem_word(20'h400) !== 32'h0000_A55A) begin
      errors++;
      $display("FAIL rm_fresh_word got %h want 0000a55a", mem_word(20'h400));
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int d0 = done_cnt;
    int t0 = tx_cnt;
    for (int i = 1; i <= 6; i++) push_rx(8'(i));
    do_start(2'b01, 20'hFFFFF, 8'd6, 8'd0);
    repeat (10) tick();
    do_start(2'b10, 20'h0, 8'd1, 8'd3);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_done got timeout want done");
    end
    tick();
    tick();
    checks++;
    if (mem_word(20'hFFFFF) !== 32'h0403_0201) begin
      errors++;
      $display("FAIL wrap_hi got %h want 04030201", mem_word(20'hFFFFF));
    end
    checks++;
    if (mem_word(20'h0) !== 32'h0000_0605) begin
      errors++;
      $display("FAIL wrap_lo got %h want 00000605", mem_word(20'h0));
    end
    checks++;
    if (done_cnt - d0 != 1 || tx_cnt != t0) begin
      errors++;
      $display("FAIL wrap_ignore got %0d/%0d want 1/0",
               done_cnt - d0, tx_cnt - t0);
    end
    checks++;
    if (byte_cnt !== 8'd6 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL wrap_end got %0d/%0d want 6/0", byte_cnt, state_o);
    end
  endtask

  task automatic test_bus_rules();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bus_owner got %0d want 0", viol);
    end
    checks++;
    if (rdn_early != 0 || wr_early != 0) begin
      errors++;
      $display("FAIL handshake got %0d/%0d want 0/0", rdn_early, wr_early);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_capture();
    test_dump();
    test_zero_len();
    test_reset_mid();
    test_wrap();
    test_bus_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
